// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers, Status/Cause bit positions
// and interrupt FSM state encoding for the CP0 interrupt unit.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int CA_IP_LO = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } cp0_state_t;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with the timer-pending flag (IP[7]).
// Ports: clk, rst, i_we_count, i_we_compare, i_wdata -> o_count, o_compare, o_pending.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we_count,
    input  logic        i_we_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_compare <= 32'hFFFF_FFFF;
            r_pending <= 1'b0;
        end else begin
            r_count <= i_we_count ? i_wdata : r_count + 32'd1;
            if (i_we_compare)
                r_compare <= i_wdata;
            // a Compare write acknowledges the timer even on a match cycle
            if (i_we_compare)
                r_pending <= 1'b0;
            else if (r_count == r_compare)
                r_pending <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule

// File: rtl/cp0_intr_unit.sv
// cp0_intr_unit: CP0 Status/Cause/EPC registers, interrupt request FSM, optional timer.
// Ports: MTC0/MFC0 (copWE, copAddr, copWrData, copRdData), IntIn, InterruptRequest/Handled,
// ResumePC, EPC. Timer (Count/Compare, IP[7]) is present only with macro CP0_TIMER_EN.
module cp0_intr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        copWE,
    input  logic [4:0]  copAddr,
    input  logic [31:0] copWrData,
    output logic [31:0] copRdData,
    input  logic [1:0]  IntIn,
    output logic        InterruptRequest,
    input  logic        InterruptHandled,
    input  logic [31:0] ResumePC,
    output logic [31:0] EPC
);

    import cp0_pkg::*;

    cp0_state_t  r_state;
    cp0_state_t  w_next;
    logic        r_ie;
    logic        r_exl;
    logic [7:0]  r_im;
    logic [1:0]  r_ip_hw;
    logic [31:0] r_epc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_tip;
    logic [7:0]  w_ip;
    logic        w_pend;
    logic        w_take;
    logic        w_wr_status;
    logic        w_wr_epc;

    assign w_wr_status = copWE && (copAddr == CP0_STATUS);
    assign w_wr_epc    = copWE && (copAddr == CP0_EPC);

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_we_count   (copWE && (copAddr == CP0_COUNT)),
        .i_we_compare (copWE && (copAddr == CP0_COMPARE)),
        .i_wdata      (copWrData),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pending    (w_tip)
    );
`else
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_tip     = 1'b0;
`endif

    assign w_ip   = {w_tip, 3'b000, r_ip_hw, 2'b00};
    assign w_pend = r_ie & ~r_exl & (|(w_ip & r_im));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        w_take           = 1'b0;
        InterruptRequest = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pend)
                    w_next = S_REQ;
            end
            S_REQ: begin
                InterruptRequest = 1'b1;
                if (InterruptHandled) begin
                    w_take = 1'b1;
                    w_next = S_SERVICE;
                end else if (!w_pend) begin
                    w_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (!r_exl)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie    <= 1'b0;
            r_exl   <= 1'b0;
            r_im    <= '0;
            r_ip_hw <= '0;
            r_epc   <= '0;
        end else begin
            r_ip_hw <= IntIn;
            if (w_wr_status) begin
                r_ie  <= copWrData[ST_IE];
                r_exl <= copWrData[ST_EXL];
                r_im  <= copWrData[ST_IM_LO +: 8];
            end
            // taking the interrupt forces EXL over a same-cycle Status write
            if (w_take)
                r_exl <= 1'b1;
            if (w_take)
                r_epc <= ResumePC;
            else if (w_wr_epc)
                r_epc <= copWrData;
        end
    end

    always_comb begin
        copRdData = '0;
        unique case (copAddr)
            CP0_COUNT:   copRdData = w_count;
            CP0_COMPARE: copRdData = w_compare;
            CP0_STATUS:  copRdData = {16'h0, r_im, 6'h0, r_exl, r_ie};
            CP0_CAUSE:   copRdData = {16'h0, w_ip, 8'h0};
            CP0_EPC:     copRdData = r_epc;
            default:     copRdData = '0;
        endcase
    end

    assign EPC = r_epc;

endmodule

// File: tb/tb_cp0_intr_unit.sv
// tb_cp0_intr_unit: directed stimulus with a behavioural CP0 model checked every
// cycle, plus literal expectations for the key interrupt and timer scenarios.
module tb_cp0_intr_unit;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        copWE;
    logic [4:0]  copAddr;
    logic [31:0] copWrData;
    logic [31:0] copRdData;
    logic [1:0]  IntIn;
    logic        InterruptRequest;
    logic        InterruptHandled;
    logic [31:0] ResumePC;
    logic [31:0] EPC;

    int checks   = 0;
    int failures = 0;

    cp0_intr_unit dut (
        .clk              (clk),
        .rst              (rst),
        .copWE            (copWE),
        .copAddr          (copAddr),
        .copWrData        (copWrData),
        .copRdData        (copRdData),
        .IntIn            (IntIn),
        .InterruptRequest (InterruptRequest),
        .InterruptHandled (InterruptHandled),
        .ResumePC         (ResumePC),
        .EPC              (EPC)
    );

    always #5 clk = ~clk;

    // model: phase 0 = idle, 1 = requesting, 2 = handler running
    int          m_phase   = 0;
    bit          m_ie      = 0;
    bit          m_exl     = 0;
    logic [7:0]  m_im      = '0;
    logic [1:0]  m_iphw    = '0;
    logic [31:0] m_epc     = '0;
    logic [31:0] m_count   = '0;
    logic [31:0] m_compare = 32'hFFFF_FFFF;
    bit          m_tip     = 0;

    logic [7:0]  t_ip;
    bit          t_pend;
    bit          t_take;
    int          t_nph;

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd9:    return TIMER ? m_count : 32'h0;
            5'd11:   return TIMER ? m_compare : 32'h0;
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_tip, 3'b000, m_iphw, 2'b00, 8'h0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_ie = 0; m_exl = 0; m_im = '0; m_iphw = '0;
            m_epc = '0; m_count = '0; m_compare = 32'hFFFF_FFFF; m_tip = 0;
        end else begin
            t_ip   = {m_tip, 3'b000, m_iphw, 2'b00};
            t_pend = m_ie && !m_exl && ((t_ip & m_im) != 8'h0);
            t_take = (m_phase == 1) && InterruptHandled;
            t_nph  = m_phase;
            if (m_phase == 0) t_nph = t_pend ? 1 : 0;
            else if (m_phase == 1) t_nph = t_take ? 2 : (t_pend ? 1 : 0);
            else if (!m_exl) t_nph = 0;
            if (copWE && copAddr == 5'd12) begin
                m_ie  = copWrData[0];
                m_exl = copWrData[1];
                m_im  = copWrData[15:8];
            end
            if (t_take) m_exl = 1;
            if (t_take) m_epc = ResumePC;
            else if (copWE && copAddr == 5'd14) m_epc = copWrData;
            if (TIMER) begin
                if (copWE && copAddr == 5'd11) m_tip = 0;
                else if (m_count == m_compare) m_tip = 1;
                if (copWE && copAddr == 5'd11) m_compare = copWrData;
                m_count = (copWE && copAddr == 5'd9) ? copWrData : m_count + 1;
            end
            m_iphw  = IntIn;
            m_phase = t_nph;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_req", {31'h0, InterruptRequest}, {31'h0, m_phase == 1});
        chk("m_epc", EPC, m_epc);
        chk("m_rd", copRdData, mread(copAddr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        copWE = 1'b1; copAddr = a; copWrData = d;
        tick();
        copWE = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        copAddr = a;
        #1;
        chk(n, copRdData, e);
    endtask

    initial begin
        rst = 1'b1; copWE = 0; copAddr = '0; copWrData = '0;
        IntIn = '0; InterruptHandled = 0; ResumePC = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_req", {31'h0, InterruptRequest}, 32'h0);
        rd(5'd12, 32'h0, "rst_status");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0, "rst_compare");

        mtc0(5'd12, 32'h0401);
        IntIn = 2'b01;
        tick();
        chk("lat_1", {31'h0, InterruptRequest}, 32'h0);
        tick();
        chk("lat_2", {31'h0, InterruptRequest}, 32'h1);
        InterruptHandled = 1; ResumePC = 32'h0000_1040;
        tick();
        InterruptHandled = 0;
        chk("svc_req", {31'h0, InterruptRequest}, 32'h0);
        chk("svc_epc", EPC, 32'h0000_1040);
        rd(5'd12, 32'h0403, "svc_status");

        InterruptHandled = 1; ResumePC = 32'h5555_5555;
        tick();
        InterruptHandled = 0;
        chk("ign_epc", EPC, 32'h0000_1040);

        mtc0(5'd12, 32'h0401);
        chk("exl_clr_req", {31'h0, InterruptRequest}, 32'h0);
        tick();
        chk("exl_idle", {31'h0, InterruptRequest}, 32'h0);
        tick();
        chk("rereq", {31'h0, InterruptRequest}, 32'h1);

        mtc0(5'd12, 32'h0);
        tick();
        chk("mask_req", {31'h0, InterruptRequest}, 32'h0);
        chk("mask_epc", EPC, 32'h0000_1040);

        mtc0(5'd12, 32'h0401);
        tick();
        chk("req2", {31'h0, InterruptRequest}, 32'h1);
        copWE = 1; copAddr = 5'd12; copWrData = 32'h0400;
        InterruptHandled = 1; ResumePC = 32'h0000_2000;
        tick();
        copWE = 0; InterruptHandled = 0;
        rd(5'd12, 32'h0402, "hs_status");
        chk("hs_epc", EPC, 32'h0000_2000);

        mtc0(5'd14, 32'hCAFE_0000);
        chk("epc_wr", EPC, 32'hCAFE_0000);

        mtc0(5'd12, 32'h0401);
        tick();
        tick();
        chk("req3", {31'h0, InterruptRequest}, 32'h1);
        copWE = 1; copAddr = 5'd14; copWrData = 32'h0000_1111;
        InterruptHandled = 1; ResumePC = 32'h0000_3000;
        tick();
        copWE = 0; InterruptHandled = 0;
        chk("epc_race", EPC, 32'h0000_3000);

        mtc0(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, 32'h0, "unimpl");
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, 32'h0000_0400, "cause_ro");

        mtc0(5'd12, 32'h0401);
        tick();
        tick();
        chk("req4", {31'h0, InterruptRequest}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'h0, InterruptRequest}, 32'h0);
        chk("rst_mid_epc", EPC, 32'h0);
        rd(5'd12, 32'h0, "rst_mid_status");
        rd(5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0, "rst_mid_compare");
        IntIn = 2'b00;
        #1 rst = 1'b0;
        tick();

`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd8);
        rd(5'd9, 32'd6, "cnt6");
        rd(5'd13, 32'h0, "tip_0");
        tick();
        tick();
        rd(5'd9, 32'd8, "cnt8");
        rd(5'd13, 32'h0, "tip_still0");
        tick();
        rd(5'd9, 32'd9, "cnt9");
        rd(5'd13, 32'h0000_8000, "tip_set");
        mtc0(5'd11, 32'h100);
        rd(5'd13, 32'h0, "tip_clr");
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, 32'hFFFF_FFFF, "cnt_max");
        tick();
        rd(5'd9, 32'h0, "cnt_wrap");
        mtc0(5'd9, 32'hFF);
        tick();
        mtc0(5'd11, 32'h100);
        rd(5'd13, 32'h0, "clr_wins");
        tick();
        rd(5'd13, 32'h0, "clr_wins2");
`else
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd8);
        rd(5'd9, 32'h0, "no_count");
        rd(5'd11, 32'h0, "no_compare");
        repeat (4) tick();
        rd(5'd13, 32'h0, "no_tip");
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_intr_unit.md
CP0_INTR_UNIT -- requirements
Module: cp0_intr_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: copWE  in  1  MTC0 write strobe from execute-stage decode.
REQ-004 SHALL have ports: copAddr  in  5  CP0 register number (rd field) for MTC0/MFC0.
REQ-005 SHALL have ports: copWrData  in  32  MTC0 source (rt value).
REQ-006 SHALL have ports: copRdData  out  32  MFC0 result, combinational from copAddr.
REQ-007 SHALL have ports: IntIn  in  2  level-sensitive external interrupt lines, synchronous to clk.
REQ-008 SHALL have ports: InterruptRequest  out  1  registered request to decode.
REQ-009 SHALL have ports: InterruptHandled  in  1  decode acceptance of request, same cycle.
REQ-010 SHALL have ports: ResumePC  in  32  PC at which execution resumes after handler.
REQ-011 SHALL have ports: EPC  out  32  saved ResumePC (register 14).

Function
REQ-012 SHALL implement registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses read 0, writes ignored.
REQ-013 Status SHALL hold IE bit0, EXL bit1, IM[7:0] bits15:8; other bits read 0.
REQ-014 Cause SHALL hold IP[7:0] bits15:8: IP[3:2] = IntIn registered each cycle, IP[7] = timer pending, others 0; Cause is read-only.
REQ-015 Count SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF->0; MTC0 to Count loads copWrData, increment resumes next cycle.
REQ-016 IP[7] SHALL set in the cycle after Count==Compare and SHALL clear on any MTC0 to Compare; set and clear in the same cycle -> clear wins.
REQ-017 FSM states IDLE, REQ, SERVICE; pend = IE & !EXL & |(IP & IM).
REQ-018 IDLE->REQ when pend; InterruptRequest=1 exactly while in REQ.
REQ-019 REQ->SERVICE when InterruptHandled: EXL<=1, EPC<=ResumePC same edge.
REQ-020 REQ->IDLE when pend falls without InterruptHandled (source removed or masked by MTC0).
REQ-021 SERVICE->IDLE when EXL is 0 (software clears EXL via MTC0 Status).
REQ-022 InterruptHandled while not in REQ SHALL be ignored.
REQ-023 MTC0 Status in the same cycle as InterruptHandled: EXL<=1 overrides written EXL; IE/IM take written value.
REQ-024 MTC0 EPC SHALL load copWrData; InterruptHandled same cycle -> ResumePC wins.
REQ-025 Request latency: IntIn asserted at edge N (with IE=1, IM set, EXL=0) -> InterruptRequest high after edge N+2.
REQ-026 copRdData SHALL reflect register contents before the current edge's write (no bypass).

Reset
REQ-027 rst SHALL force: FSM=IDLE, InterruptRequest=0, Count=0, Compare=0xFFFFFFFF, Status=0, IP=0, EPC=0.
REQ-028 rst asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt with no EPC update.

Configuration
REQ-029 Macro CP0_TIMER_EN defined: Count/Compare/IP[7] as specified.
REQ-030 CP0_TIMER_EN undefined: no Count/Compare hardware, registers 9/11 read 0, writes ignored, IP[7]=0.

Structure
REQ-031 Shared package cp0_pkg SHALL hold CP0 register numbers, Status/Cause bit positions, FSM state encoding.
REQ-032 Timer SHALL be sub-module cp0_timer (Count, Compare, pending flag), instantiated only under CP0_TIMER_EN.

Verification
REQ-033 IE=1, IM=0x04, IntIn=2'b01 -> InterruptRequest high two cycles later; InterruptHandled with ResumePC=0x00001040 -> EPC=0x00001040, EXL=1, request low.
REQ-034 Count=5, Compare=8 -> IP[7] set when Count reads 9; MTC0 Compare=0x100 -> IP[7] cleared next cycle.
REQ-035 In REQ, MTC0 Status=0 -> state IDLE, InterruptRequest low next cycle, EPC unchanged.
REQ-036 In SERVICE, MTC0 Status=0x0401 -> state IDLE, re-request if IntIn still high.
REQ-037 MTC0 Status=0x0400 same cycle as InterruptHandled -> Status reads 0x0402.
REQ-038 rst asserted during REQ -> InterruptRequest 0 immediately, Status=0, EPC=0, Compare=0xFFFFFFFF.
